// File: rtl/de_shift_reg.sv
// rtl/de_shift_reg.sv - loadable, bidirectional shift/rotate register with saturating shift counter
module de_shift_reg #(
    parameter int                WIDTH       = 8,
    parameter int                ROTATE      = 0,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    localparam int               CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             E,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_RIGHT = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic fill_l;
    logic fill_r;
    logic cnt_sat;

    // ROTATE is elaboration-time, so sin is structurally cut off in rotate builds
    generate
        if (ROTATE != 0) begin : g_rotate
            assign fill_l = Q[WIDTH-1];
            assign fill_r = Q[0];
        end else begin : g_serial
            assign fill_l = sin;
            assign fill_r = sin;
        end
    endgenerate

    assign cnt_sat = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q   <= RESET_VALUE;
            cnt <= '0;
        end else if (clr) begin
            Q   <= RESET_VALUE;
            cnt <= '0;
        end else if (E) begin
            case (mode)
                MODE_LOAD: begin
                    Q   <= D;
                    cnt <= '0;
                end
                MODE_LEFT: begin
                    Q <= {Q[WIDTH-2:0], fill_l};
                    if (!cnt_sat) cnt <= cnt + 1'b1;
                end
                MODE_RIGHT: begin
                    Q <= {fill_r, Q[WIDTH-1:1]};
                    if (!cnt_sat) cnt <= cnt + 1'b1;
                end
                default: begin
                    Q   <= Q;
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign sout_l = Q[WIDTH-1];
    assign sout_r = Q[0];
    assign done   = cnt_sat;

endmodule

// File: tb/tb_de_shift_reg.sv
// tb/tb_de_shift_reg.sv - scoreboard bench for de_shift_reg, serial (dut0) and rotate (dut1) builds
module tb_de_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       E = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] D = 8'h00;
    logic       sin = 1'b0;

    logic [7:0] q0, q1;
    logic       sl0, sr0, sl1, sr1;
    logic [3:0] cnt0, cnt1;
    logic       done0, done1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       done;
        string      name;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    de_shift_reg #(.WIDTH(8), .ROTATE(0), .RESET_VALUE(8'h00)) dut0 (
        .clk(clk), .reset(reset), .E(E), .clr(clr), .mode(mode), .D(D), .sin(sin),
        .Q(q0), .sout_l(sl0), .sout_r(sr0), .cnt(cnt0), .done(done0)
    );

    de_shift_reg #(.WIDTH(8), .ROTATE(1), .RESET_VALUE(8'h00)) dut1 (
        .clk(clk), .reset(reset), .E(E), .clr(clr), .mode(mode), .D(D), .sin(sin),
        .Q(q1), .sout_l(sl1), .sout_r(sr1), .cnt(cnt1), .done(done1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_dut(input int which, input exp_t e);
        if (which == 0) begin
            chk({e.name, " Q"}, 32'(q0), 32'(e.q));
            chk({e.name, " cnt"}, 32'(cnt0), 32'(e.cnt));
            chk({e.name, " done"}, 32'(done0), 32'(e.done));
            chk({e.name, " souts"}, {30'd0, sl0, sr0}, {30'd0, e.q[7], e.q[0]});
        end else begin
            chk({e.name, " Q"}, 32'(q1), 32'(e.q));
            chk({e.name, " cnt"}, 32'(cnt1), 32'(e.cnt));
            chk({e.name, " done"}, 32'(done1), 32'(e.done));
            chk({e.name, " souts"}, {30'd0, sl1, sr1}, {30'd0, e.q[7], e.q[0]});
        end
    endtask

    // Monitor: every rising edge, the state expected after that edge is popped and compared
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                chk_dut(0, e);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                chk_dut(1, e);
            end
        end
    end

    // Called at a falling edge: drive inputs, queue the state expected after the next rising edge
    task automatic step(input int which, input logic e_i, input logic clr_i, input logic [1:0] mode_i,
                        input logic [7:0] d_i, input logic sin_i,
                        input logic [7:0] eq, input logic [3:0] ec, input string nm);
        exp_t x;
        E = e_i; clr = clr_i; mode = mode_i; D = d_i; sin = sin_i;
        x.q = eq; x.cnt = ec; x.done = (ec == 4'd8); x.name = nm;
        if (which == 0) sb0.push_back(x);
        else            sb1.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_q;
        @(negedge clk);
        #1;
        chk("reset dut0 Q", 32'(q0), 32'h00);
        chk("reset dut0 cnt/done", {cnt0, done0}, 5'b0);
        chk("reset dut1 Q/cnt", {q1, cnt1}, 12'h000);
        @(negedge clk);
        reset = 1'b1;

        // async reset mid-cycle and hold through edges
        step(0, 1, 0, 2'b01, 8'hA5, 0, 8'hA5, 4'd0, "load A5");
        #2 reset = 1'b0;
        #1;
        chk("async reset Q", 32'(q0), 32'h00);
        chk("async reset cnt/done", {cnt0, done0}, 5'b0);
        @(negedge clk);
        step(0, 1, 0, 2'b01, 8'hFF, 1, 8'h00, 4'd0, "in reset 1");
        step(0, 1, 0, 2'b10, 8'hFF, 1, 8'h00, 4'd0, "in reset 2");
        reset = 1'b1;

        // enable gating, then load, then falling edge leaves Q alone
        step(0, 0, 0, 2'b01, 8'hFF, 0, 8'h00, 4'd0, "E0 load 1");
        step(0, 0, 0, 2'b01, 8'hFF, 0, 8'h00, 4'd0, "E0 load 2");
        step(0, 1, 0, 2'b01, 8'hFF, 0, 8'hFF, 4'd0, "E1 load FF");
        E = 1'b0;
        #1;
        chk("falling edge Q", 32'(q0), 32'hFF);
        step(0, 1, 0, 2'b00, 8'h12, 1, 8'hFF, 4'd0, "mode hold");

        // 8 left shifts of 81 with sin=0, then saturation
        step(0, 1, 0, 2'b01, 8'h81, 0, 8'h81, 4'd0, "load 81");
        exp_q = 8'h81;
        for (int i = 1; i <= 8; i++) begin
            exp_q = {exp_q[6:0], 1'b0};
            step(0, 1, 0, 2'b10, 8'hXX, 0, exp_q, 4'(i), $sformatf("shl %0d", i));
        end
        step(0, 1, 0, 2'b10, 8'h00, 0, 8'h00, 4'd8, "shl 9 sat");
        step(0, 1, 0, 2'b10, 8'h00, 1, 8'h01, 4'd8, "shl 10 sin1");
        step(0, 1, 0, 2'b01, 8'h3C, 0, 8'h3C, 4'd0, "load after done");

        // build Q=3C cnt=5, then clear with E=0
        step(0, 1, 0, 2'b01, 8'h01, 0, 8'h01, 4'd0, "load 01");
        step(0, 1, 0, 2'b10, 8'h00, 1, 8'h03, 4'd1, "build 1");
        step(0, 1, 0, 2'b10, 8'h00, 1, 8'h07, 4'd2, "build 2");
        step(0, 1, 0, 2'b10, 8'h00, 1, 8'h0F, 4'd3, "build 3");
        step(0, 1, 0, 2'b10, 8'h00, 0, 8'h1E, 4'd4, "build 4");
        step(0, 1, 0, 2'b10, 8'h00, 0, 8'h3C, 4'd5, "build 5");
        step(0, 0, 1, 2'b10, 8'hFF, 1, 8'h00, 4'd0, "clr E0");

        // direction change keeps counting, then load resets cnt
        step(0, 1, 0, 2'b10, 8'h00, 1, 8'h01, 4'd1, "mix shl 1");
        step(0, 1, 0, 2'b10, 8'h00, 1, 8'h03, 4'd2, "mix shl 2");
        step(0, 1, 0, 2'b10, 8'h00, 1, 8'h07, 4'd3, "mix shl 3");
        step(0, 1, 0, 2'b11, 8'h00, 0, 8'h03, 4'd4, "mix shr 1");
        step(0, 1, 0, 2'b11, 8'h00, 0, 8'h01, 4'd5, "mix shr 2");
        step(0, 1, 0, 2'b01, 8'h55, 0, 8'h55, 4'd0, "mix load 55");

        // rotate build: sin ignored
        step(1, 1, 0, 2'b01, 8'h01, 1, 8'h01, 4'd0, "rot load 01");
        exp_q = 8'h01;
        for (int i = 1; i <= 8; i++) begin
            exp_q = {exp_q[0], exp_q[7:1]};
            step(1, 1, 0, 2'b11, 8'hXX, 1'bx, exp_q, 4'(i), $sformatf("rotr %0d", i));
        end
        step(1, 1, 0, 2'b10, 8'hFF, 0, 8'h02, 4'd8, "rotl sat");
        step(1, 1, 1, 2'b10, 8'hFF, 0, 8'h00, 4'd0, "rot clr");

        E = 1'b0; clr = 1'b0; mode = 2'b00;
        for (int i = 0; i < 10 && (sb0.size() > 0 || sb1.size() > 0); i++) @(negedge clk);
        if (sb0.size() > 0 || sb1.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb0.size() + sb1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/de_shift_reg.md
DE_SHIFT_REG -- requirements
Module: de_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter ROTATE, default 0; 1 = shifted-out bit re-enters the opposite end instead of sin.
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit value Q takes on reset and on clr.
REQ-004 clk  input  1  single clock; all state changes on rising edge except reset.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 E  input  1  enable; 0 = hold all state (clr excepted).
REQ-007 clr  input  1  synchronous clear, independent of E.
REQ-008 mode  input  2  00 hold, 01 parallel load, 10 shift left, 11 shift right.
REQ-009 D  input  WIDTH  parallel load data.
REQ-010 sin  input  1  serial input bit for shifts when ROTATE=0.
REQ-011 Q  output  WIDTH  register contents.
REQ-012 sout_l  output  1  equals Q[WIDTH-1], combinational from Q.
REQ-013 sout_r  output  1  equals Q[0], combinational from Q.
REQ-014 cnt  output  clog2(WIDTH+1)  shifts performed since last load/clear, saturating.
REQ-015 done  output  1  high while cnt == WIDTH, combinational from cnt.

Function
REQ-016 Edge priority SHALL be: reset (async) > clr > E=0 hold > mode.
REQ-017 clr=1 at rising edge SHALL set Q=RESET_VALUE, cnt=0, regardless of E and mode.
REQ-018 E=0 and clr=0 SHALL leave Q and cnt unchanged, whatever mode, D, sin do.
REQ-019 Falling clock edges SHALL never change Q or cnt.
REQ-020 mode=00, E=1: Q and cnt unchanged.
REQ-021 mode=01, E=1: Q <= D, cnt <= 0; one-cycle latency, Q valid after that edge.
REQ-022 mode=10, E=1: Q <= {Q[WIDTH-2:0], fill}, fill = sin (ROTATE=0) or Q[WIDTH-1] (ROTATE=1).
REQ-023 mode=11, E=1: Q <= {fill, Q[WIDTH-1:1]}, fill = sin (ROTATE=0) or Q[0] (ROTATE=1).
REQ-024 Each enabled shift SHALL increment cnt by 1, saturating at WIDTH (no wrap to 0).
REQ-025 Shifting continues to modify Q after cnt saturates; only cnt holds.
REQ-026 Direction change mid-sequence SHALL NOT reset cnt; both directions count.
REQ-027 done SHALL rise in the same cycle cnt reaches WIDTH and fall on the edge of the next load or clr.
REQ-028 sin SHALL be ignored when ROTATE=1; D SHALL be ignored except in mode 01.
REQ-029 No X SHALL propagate to outputs from undriven D/sin when those inputs are ignored.

Reset
REQ-030 reset=0 SHALL immediately, without clock, force Q=RESET_VALUE, cnt=0, done=0.
REQ-031 While reset=0, clock edges and all inputs SHALL have no effect.
REQ-032 Reset asserted mid-shift-sequence SHALL abort it; after release the first enabled edge acts from Q=RESET_VALUE, cnt=0.
REQ-033 Reset release SHALL be treated as synchronous to clk by the environment; first effective edge is the first rising edge with reset=1.

Verification (WIDTH=8, RESET_VALUE=0 unless stated)
REQ-034 reset=0 mid-cycle with Q=8'hA5 -> Q=8'h00, cnt=0 before next clk edge; held through 2 edges.
REQ-035 E=0, mode=01, D=8'hFF for 2 cycles -> Q stays 8'h00; then E=1 -> Q=8'hFF after one rising edge, unchanged at falling edge.
REQ-036 Load 8'h81, ROTATE=0, sin=0, mode=10 for 8 cycles -> Q sequence 02,04,...,00; cnt 1..8; done=1 on 8th; 9th shift keeps cnt=8.
REQ-037 ROTATE=1, load 8'h01, mode=11 for 8 cycles -> Q 80,40,...,01; sout_r=1 only at start and end; done=1.
REQ-038 clr=1 with E=0, Q=8'h3C, cnt=5 -> Q=8'h00, cnt=0, done=0 after edge.
REQ-039 3 left shifts, then 2 right shifts, then load 8'h55 -> cnt 1,2,3,4,5 then 0; Q=8'h55.
